// File: rtl/lc3_decode_stage.sv
// LC-3 decode stage: registers the fetched instruction and next PC, and
// derives the execute / writeback / memory control words from the opcode.
module lc3_decode_stage #(
    parameter int INSTR_W = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable_decode,
    input  logic [INSTR_W-1:0] dout,
    input  logic [INSTR_W-1:0] npc_in,
    output logic [INSTR_W-1:0] instr_dout,
    output logic [INSTR_W-1:0] npc_out,
    output logic [5:0]         E_control_i,
    output logic [1:0]         W_control_i,
    output logic               Mem_control_i,
    output logic               inst_valid
);

    typedef enum logic [3:0] {
        OP_BR  = 4'b0000,
        OP_ADD = 4'b0001,
        OP_LD  = 4'b0010,
        OP_ST  = 4'b0011,
        OP_AND = 4'b0101,
        OP_LDR = 4'b0110,
        OP_STR = 4'b0111,
        OP_NOT = 4'b1001,
        OP_LDI = 4'b1010,
        OP_STI = 4'b1011,
        OP_JMP = 4'b1100,
        OP_LEA = 4'b1110
    } opcode_e;

    localparam logic [1:0] PC1_OFF11 = 2'b00;
    localparam logic [1:0] PC1_OFF9  = 2'b01;
    localparam logic [1:0] PC1_OFF6  = 2'b10;
    localparam logic [1:0] PC1_ZERO  = 2'b11;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC  = 2'b10;

    logic [3:0] opcode;
    logic       imm_bit;

    logic [1:0] alu_control;
    logic [1:0] pcselect1;
    logic       pcselect2;
    logic       op2select;
    logic [1:0] w_dec;
    logic       m_dec;
    logic       v_dec;

    logic [INSTR_W-1:0] instr_d, instr_q;
    logic [INSTR_W-1:0] npc_d,   npc_q;
    logic [5:0]         e_ctrl_d, e_ctrl_q;
    logic [1:0]         w_ctrl_d, w_ctrl_q;
    logic               m_ctrl_d, m_ctrl_q;
    logic               valid_d,  valid_q;

    assign opcode  = dout[15:12];
    assign imm_bit = dout[5];

    // Control fields not used by an opcode stay at their zero defaults.
    always_comb begin
        alu_control = 2'b00;
        pcselect1   = PC1_OFF11;
        pcselect2   = 1'b0;
        op2select   = 1'b0;
        w_dec       = WB_ALU;
        m_dec       = 1'b0;
        v_dec       = 1'b1;
        case (opcode)
            OP_ADD: begin
                alu_control = 2'b00;
                op2select   = ~imm_bit;
            end
            OP_AND: begin
                alu_control = 2'b01;
                op2select   = ~imm_bit;
            end
            OP_NOT: begin
                alu_control = 2'b10;
                op2select   = 1'b1;
            end
            OP_BR: begin
                pcselect1 = PC1_OFF9;
                pcselect2 = 1'b1;
            end
            OP_JMP: begin
                pcselect1 = PC1_ZERO;
                pcselect2 = 1'b0;
            end
            OP_LD: begin
                pcselect1 = PC1_OFF9;
                pcselect2 = 1'b1;
                w_dec     = WB_MEM;
            end
            OP_LDR: begin
                pcselect1 = PC1_OFF6;
                pcselect2 = 1'b0;
                w_dec     = WB_MEM;
            end
            OP_LDI: begin
                pcselect1 = PC1_OFF9;
                pcselect2 = 1'b1;
                w_dec     = WB_MEM;
                m_dec     = 1'b1;
            end
            OP_LEA: begin
                pcselect1 = PC1_OFF9;
                pcselect2 = 1'b1;
                w_dec     = WB_PC;
            end
            OP_ST: begin
                pcselect1 = PC1_OFF9;
                pcselect2 = 1'b1;
            end
            OP_STR: begin
                pcselect1 = PC1_OFF6;
                pcselect2 = 1'b0;
            end
            OP_STI: begin
                pcselect1 = PC1_OFF9;
                pcselect2 = 1'b1;
                m_dec     = 1'b1;
            end
            default: begin
                v_dec = 1'b0;
            end
        endcase
    end

    // Hold everything while the controller stalls decode.
    always_comb begin
        instr_d  = instr_q;
        npc_d    = npc_q;
        e_ctrl_d = e_ctrl_q;
        w_ctrl_d = w_ctrl_q;
        m_ctrl_d = m_ctrl_q;
        valid_d  = valid_q;
        if (enable_decode) begin
            instr_d  = dout;
            npc_d    = npc_in;
            e_ctrl_d = {alu_control, pcselect1, pcselect2, op2select};
            w_ctrl_d = w_dec;
            m_ctrl_d = m_dec;
            valid_d  = v_dec;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            instr_q  <= '0;
            npc_q    <= '0;
            e_ctrl_q <= '0;
            w_ctrl_q <= '0;
            m_ctrl_q <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            instr_q  <= instr_d;
            npc_q    <= npc_d;
            e_ctrl_q <= e_ctrl_d;
            w_ctrl_q <= w_ctrl_d;
            m_ctrl_q <= m_ctrl_d;
            valid_q  <= valid_d;
        end
    end

    assign instr_dout    = instr_q;
    assign npc_out       = npc_q;
    assign E_control_i   = e_ctrl_q;
    assign W_control_i   = w_ctrl_q;
    assign Mem_control_i = m_ctrl_q;
    assign inst_valid    = valid_q;

endmodule

// File: tb/tb_lc3_decode_stage.sv
// Directed bench for lc3_decode_stage with hand-computed expected control words.
module tb_lc3_decode_stage;

    logic        clock;
    logic        reset;
    logic        enable_decode;
    logic [15:0] dout;
    logic [15:0] npc_in;
    logic [15:0] instr_dout;
    logic [15:0] npc_out;
    logic [5:0]  E_control_i;
    logic [1:0]  W_control_i;
    logic        Mem_control_i;
    logic        inst_valid;

    int errors = 0;
    int checks = 0;

    lc3_decode_stage #(.INSTR_W(16)) dut (
        .clock        (clock),
        .reset        (reset),
        .enable_decode(enable_decode),
        .dout         (dout),
        .npc_in       (npc_in),
        .instr_dout   (instr_dout),
        .npc_out      (npc_out),
        .E_control_i  (E_control_i),
        .W_control_i  (W_control_i),
        .Mem_control_i(Mem_control_i),
        .inst_valid   (inst_valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [15:0] ir, input logic [15:0] npc,
                             input logic [5:0] e, input logic [1:0] w, input logic m,
                             input logic v);
        check({tag, ".ir"},  {16'h0, instr_dout},    {16'h0, ir});
        check({tag, ".npc"}, {16'h0, npc_out},       {16'h0, npc});
        check({tag, ".E"},   {26'h0, E_control_i},   {26'h0, e});
        check({tag, ".W"},   {30'h0, W_control_i},   {30'h0, w});
        check({tag, ".M"},   {31'h0, Mem_control_i}, {31'h0, m});
        check({tag, ".V"},   {31'h0, inst_valid},    {31'h0, v});
        $display("txn %-8s ir=%04h npc=%04h E=%06b W=%02b M=%0d V=%0d", tag,
                 instr_dout, npc_out, E_control_i, W_control_i, Mem_control_i, inst_valid);
    endtask

    // Advance one edge and sample 1 ns after it.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic load(input logic [15:0] instr, input logic [15:0] npc);
        dout          = instr;
        npc_in        = npc;
        enable_decode = 1'b1;
        step();
    endtask

    typedef struct {
        string       tag;
        logic [15:0] instr;
        logic [15:0] npc;
        logic [5:0]  e;
        logic [1:0]  w;
        logic        m;
        logic        v;
    } vec_t;

    vec_t vecs[$];

    initial begin
        vecs.push_back('{"ADDi",  16'h12A3, 16'h3001, 6'b000000, 2'b00, 1'b0, 1'b1});
        vecs.push_back('{"ADDr",  16'h1282, 16'h3002, 6'b000001, 2'b00, 1'b0, 1'b1});
        vecs.push_back('{"LDI",   16'hA205, 16'h3003, 6'b000110, 2'b01, 1'b1, 1'b1});
        vecs.push_back('{"STR",   16'h7442, 16'h3004, 6'b001000, 2'b00, 1'b0, 1'b1});
        vecs.push_back('{"LEA",   16'hE1FF, 16'h3005, 6'b000110, 2'b10, 1'b0, 1'b1});
        vecs.push_back('{"AND",   16'h5262, 16'h3006, 6'b010000, 2'b00, 1'b0, 1'b1});
        vecs.push_back('{"ANDr",  16'h5242, 16'h3007, 6'b010001, 2'b00, 1'b0, 1'b1});
        vecs.push_back('{"NOT",   16'h927F, 16'h3008, 6'b100001, 2'b00, 1'b0, 1'b1});
        vecs.push_back('{"ILL_D", 16'hD000, 16'h3009, 6'b000000, 2'b00, 1'b0, 1'b0});
        vecs.push_back('{"BR",    16'h0E05, 16'h300A, 6'b000110, 2'b00, 1'b0, 1'b1});
        vecs.push_back('{"JMP",   16'hC1C0, 16'h300B, 6'b001100, 2'b00, 1'b0, 1'b1});
        vecs.push_back('{"LD",    16'h2403, 16'h300C, 6'b000110, 2'b01, 1'b0, 1'b1});
        vecs.push_back('{"LDR",   16'h6643, 16'h300D, 6'b001000, 2'b01, 1'b0, 1'b1});
        vecs.push_back('{"ST",    16'h3607, 16'h300E, 6'b000110, 2'b00, 1'b0, 1'b1});
        vecs.push_back('{"ILL_4", 16'h4800, 16'h300F, 6'b000000, 2'b00, 1'b0, 1'b0});
        vecs.push_back('{"ILL_8", 16'h8000, 16'h3010, 6'b000000, 2'b00, 1'b0, 1'b0});
        vecs.push_back('{"ILL_F", 16'hF025, 16'h3011, 6'b000000, 2'b00, 1'b0, 1'b0});
        vecs.push_back('{"STI",   16'hB401, 16'h3012, 6'b000110, 2'b00, 1'b1, 1'b1});

        reset         = 1'b0;
        enable_decode = 1'b1;
        dout          = 16'h12A3;
        npc_in        = 16'h3001;
        #1;
        check_all("rst_imm", 16'h0, 16'h0, 6'b0, 2'b0, 1'b0, 1'b0);
        repeat (3) step();
        check_all("rst", 16'h0, 16'h0, 6'b0, 2'b0, 1'b0, 1'b0);

        enable_decode = 1'b0;
        reset         = 1'b1;
        repeat (2) step();
        check_all("rel_stl", 16'h0, 16'h0, 6'b0, 2'b0, 1'b0, 1'b0);

        // Back-to-back captures, one instruction per edge.
        foreach (vecs[i]) begin
            load(vecs[i].instr, vecs[i].npc);
            check_all(vecs[i].tag, vecs[i].instr, vecs[i].npc, vecs[i].e, vecs[i].w,
                      vecs[i].m, vecs[i].v);
        end

        // Stall hold while dout toggles; also proves no combinational path.
        load(16'hA205, 16'h4000);
        enable_decode = 1'b0;
        for (int k = 0; k < 4; k++) begin
            dout   = (k % 2 == 0) ? 16'h0000 : 16'hFFFF;
            npc_in = 16'h5000 + 16'(k);
            #1;
            check_all("stl_comb", 16'hA205, 16'h4000, 6'b000110, 2'b01, 1'b1, 1'b1);
            step();
            check_all("stall", 16'hA205, 16'h4000, 6'b000110, 2'b01, 1'b1, 1'b1);
        end
        enable_decode = 1'b1;
        step();
        check_all("reen", 16'hFFFF, 16'h5003, 6'b000000, 2'b00, 1'b0, 1'b0);

        // Asynchronous reset between edges while holding STI.
        load(16'hB401, 16'h6001);
        check_all("sti", 16'hB401, 16'h6001, 6'b000110, 2'b00, 1'b1, 1'b1);
        enable_decode = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check_all("arst", 16'h0, 16'h0, 6'b0, 2'b0, 1'b0, 1'b0);
        step();
        reset = 1'b1;
        repeat (2) step();
        check_all("arst_rel", 16'h0, 16'h0, 6'b0, 2'b0, 1'b0, 1'b0);
        load(16'hB401, 16'h6002);
        check_all("arst_cap", 16'hB401, 16'h6002, 6'b000110, 2'b00, 1'b1, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
